// File: rtl/player_input_port_pkg.sv
// player_input_port_pkg: register offsets, state encodings and sizes for player_input_port.
package player_input_port_pkg;
   localparam int NUM_PLAYERS = 4;
   localparam int PIN_GROUP_W = 5;
   localparam logic [2:0] STATUS_OFF = 3'd0;
   localparam logic [2:0] PLAYER0_OFF = 3'd1;
   localparam logic [2:0] SWITCH_OFF = 3'd5;
   localparam int ARM_BIT = 0;

   typedef enum logic [1:0] {IDLE, WAIT_PRESS, PRESSED, WAIT_RELEASE} deb_state_t;
   typedef enum logic {ARMED, LOCKED} round_state_t;

   function automatic logic [1:0] first_of(input logic [3:0] p);
      return p[0] ? 2'd0 : p[1] ? 2'd1 : p[2] ? 2'd2 : 2'd3;
   endfunction
endpackage

// File: rtl/player_input_port_debounce.sv
// button_debounce: synchronises one active-high fire pin and emits a one-cycle press pulse.
// PLAYER_INPUT_DEBOUNCE_EN selects the counted debounce FSM; otherwise a plain rising-edge detect.
module button_debounce
   import player_input_port_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic fire_in,
   output logic press
);
   logic s1_q, s2_q;
   logic unused_cfg;
   assign unused_cfg = (DEBOUNCE_CYCLES != 0);
`ifdef PLAYER_INPUT_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
   deb_state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         state_q <= IDLE;
         cnt_q <= '0;
      end else begin
         s1_q <= fire_in;
         s2_q <= s1_q;
         state_q <= state_d;
         cnt_q <= cnt_d;
      end
   end
   // The same counter times both the press and the release; it is cleared on every state change.
   always_comb begin
      state_d = state_q;
      cnt_d = '0;
      case (state_q)
         IDLE: state_d = s2_q ? WAIT_PRESS : IDLE;
         WAIT_PRESS: begin
            state_d = !s2_q ? IDLE : (cnt_q == LAST) ? PRESSED : WAIT_PRESS;
            cnt_d = (s2_q && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
         end
         PRESSED: state_d = WAIT_RELEASE;
         WAIT_RELEASE: begin
            state_d = (!s2_q && cnt_q == LAST) ? IDLE : WAIT_RELEASE;
            cnt_d = (!s2_q && cnt_q != LAST) ? cnt_q + 1'b1 : '0;
         end
      endcase
   end
   assign press = (state_q == PRESSED);
`else
   logic s3_q, p_q, p_d;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q <= 1'b0;
         s2_q <= 1'b0;
         s3_q <= 1'b0;
         p_q <= 1'b0;
      end else begin
         s1_q <= fire_in;
         s2_q <= s1_q;
         s3_q <= s2_q;
         p_q <= p_d;
      end
   end
   always_comb p_d = s2_q && !s3_q;
   assign press = p_q;
`endif
endmodule

// File: rtl/player_input_port.sv
// player_input_port: I/O-mapped responder latching player hex entries and the first presser per round.
// Define PLAYER_INPUT_DEBOUNCE_EN to debounce the fire pins; otherwise presses are raw edges.
module player_input_port
   import player_input_port_pkg::*;
#(
   parameter logic [15:0] BASE_ADR = 16'd43,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [35:0] gpins,
   input  logic [15:0] adr,
   input  logic        memread,
   input  logic        memwrite,
   input  logic [15:0] writedata,
   output logic [15:0] rddata,
   output logic        firstPlayerFlag
);
   logic [19:0] nib_s1_d, nib_s1_q, nib_s2_q;
   logic [NUM_PLAYERS-1:0] p, pending_q, pending_d, rd_clr;
   logic [NUM_PLAYERS-1:0][3:0] val_q, val_d;
   logic [1:0] first_idx_q, first_idx_d;
   round_state_t round_q, round_d;
   logic [15:0] rddata_q, rddata_d, rd_val;
   logic [2:0] off;
   logic sel, rd, arm, take;
   logic unused_bits;

   assign unused_bits = ^{gpins[35:24], writedata[15:1]};

   for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_btn
      button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
         .clk(clk),
         .rst(rst),
         .fire_in(!gpins[PIN_GROUP_W*g+4]),
         .press(p[g])
      );
   end

   // Value nibbles of players 0..3 in [15:0], switches in [19:16], all made active-high.
   always_comb begin
      nib_s1_d = {~gpins[23:20], 16'd0};
      for (int i = 0; i < NUM_PLAYERS; i++) nib_s1_d[4*i +: 4] = ~gpins[PIN_GROUP_W*i +: 4];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         nib_s1_q <= '0;
         nib_s2_q <= '0;
         pending_q <= '0;
         val_q <= '0;
         first_idx_q <= '0;
         round_q <= ARMED;
         rddata_q <= '0;
      end else begin
         nib_s1_q <= nib_s1_d;
         nib_s2_q <= nib_s1_q;
         pending_q <= pending_d;
         val_q <= val_d;
         first_idx_q <= first_idx_d;
         round_q <= round_d;
         rddata_q <= rddata_d;
      end
   end

   assign off = 3'(adr - BASE_ADR);

   // A press that coincides with the read-clear of its own player is accepted; an arm write beats everything.
   always_comb begin
      sel = (adr >= BASE_ADR) && (adr <= BASE_ADR + 16'd5);
      rd = memread && sel;
      arm = memwrite && sel && (off == STATUS_OFF) && writedata[ARM_BIT];
      pending_d = pending_q;
      val_d = val_q;
      first_idx_d = first_idx_q;
      round_d = round_q;
      rd_clr = '0;
      take = 1'b0;
      for (int i = 0; i < NUM_PLAYERS; i++) begin
         rd_clr[i] = rd && (off == 3'(PLAYER0_OFF + 3'(i)));
         take = p[i] && (!pending_q[i] || rd_clr[i]);
         pending_d[i] = arm ? 1'b0 : take ? 1'b1 : rd_clr[i] ? 1'b0 : pending_q[i];
         val_d[i] = arm ? 4'd0 : take ? nib_s2_q[4*i +: 4] : val_q[i];
      end
      if (arm) begin
         first_idx_d = 2'd0;
         round_d = ARMED;
      end else if (round_q == ARMED && |p) begin
         first_idx_d = first_of(p);
         round_d = LOCKED;
      end
      rd_val = (off == STATUS_OFF) ? {9'd0, round_q == LOCKED, first_idx_q, pending_q}
             : (off == SWITCH_OFF) ? {12'd0, nib_s2_q[19:16]}
             : {11'd0, pending_q[2'(off - 3'd1)], val_q[2'(off - 3'd1)]};
      rddata_d = rd ? rd_val : 16'd0;
   end

   assign rddata = rddata_q;
   assign firstPlayerFlag = (round_q == LOCKED);
endmodule
